big2_turn_ctrl: RTL
===================

BIG2_TURN_CTRL -- requirements
Module: big2_turn_ctrl

Interface
REQ-001 clka  in  1  single system clock; all logic on rising edge.
REQ-002 restart  in  1  synchronous, active-high reset.
REQ-003 start  in  1  level; begin a new game when sampled high in IDLE or OVER.
REQ-004 seed_in  in  4  shuffle seed, captured on start.
REQ-005 deal_done  in  1  dealer completion level; only its rising edge is used.
REQ-006 p_req / c_req  in  1  player / computer move valid, single-cycle.
REQ-007 p_pass / c_pass  in  1  qualifies req: move is a pass.
REQ-008 p_num / c_num  in  3  cards played with a non-pass req.
REQ-009 card_gen  out  1  one-cycle deal request to the dealer.
REQ-010 seed  out  4  captured seed, held stable until the next start.
REQ-011 p_grant / c_grant  out  1  one-hot turn ownership; both low outside turn states.
REQ-012 lead  out  1  current mover leads a fresh trick.
REQ-013 p_left / c_left  out  3  cards remaining per hand.
REQ-014 game_over  out  1  level, high in OVER.
REQ-015 winner  out  1  0 = player, 1 = computer; valid while game_over.
REQ-016 err  out  1  one-cycle pulse on any illegal move or deal timeout.
REQ-017 deal_fail  out  1  sticky; cleared by start or restart.

Function
REQ-018 States: IDLE, DEAL_REQ, DEAL_WAIT, P_TURN, C_TURN, OVER.
REQ-019 IDLE/OVER with start=1: capture seed, clear deal_fail and retry count, go to DEAL_REQ.
REQ-020 DEAL_REQ: card_gen=1 for exactly one cycle, clear the watchdog, go to DEAL_WAIT.
REQ-021 DEAL_WAIT, on a deal_done rising edge (deal_done=1, previous sample 0):
- p_left=c_left=4
- lead=1
- go to P_TURN, because the player always holds the low card.
REQ-022 Deal watchdog: 8-bit counter runs in DEAL_WAIT; on reaching 255 without a deal_done edge:
- pulse err and increment the 2-bit retry count
- on the first or second timeout, go back to DEAL_REQ
- on the third timeout, set deal_fail and go to IDLE.
REQ-023 In P_TURN, only p_* inputs are evaluated; c_* inputs are ignored (and vice versa in C_TURN).
REQ-024 Pass rules (req=1, pass=1):
- lead=1: illegal; pulse err, stay in state, no counter change
- lead=0: go to the opponent's turn with lead=1 (two-player: the last mover's opponent leads).
REQ-025 Play rules (req=1, pass=0):
- num==0 or num>left: illegal; pulse err, state unchanged
- otherwise left<=left-num, lead<=0, switch to the opponent's turn.
REQ-026 If left reaches 0 on a legal play: go to OVER, winner=mover, both grants low next cycle.
REQ-027 Turn latency: a grant flips exactly one cycle after the accepted req; no req is accepted in the cycle a grant changes owner.
REQ-028 start is ignored outside IDLE/OVER; deal_done is ignored outside DEAL_WAIT.
REQ-029 Arithmetic is unsigned 3-bit; an underflow is impossible by REQ-025.

Reset
REQ-030 restart=1 forces, on the next edge, regardless of state (including mid-deal or mid-turn):
- state IDLE
- card_gen, grants, lead, err, game_over, winner, deal_fail = 0
- seed, p_left, c_left = 0
- watchdog, retry count and deal_done history = 0.
REQ-031 restart has priority over all other inputs in the same cycle.

Structure
REQ-032 Shared package big2_pkg SHALL hold:
- state encoding (3-bit)
- HAND_SIZE=4
- DEAL_TIMEOUT=255
- MAX_RETRY=3
- LOW_CARD=6'b000011.
REQ-033 One sub-module, big2_deal_watchdog, SHALL contain:
- the deal_done edge detector
- the timeout counter
- the retry counter.
Its outputs are done_edge, timeout and fail.

Verification
REQ-034 Reset then start, seed_in=4'hA, deal_done rising 5 cycles later -> card_gen high 1 cycle, seed=4'hA, P_TURN with p_left=c_left=4 and lead=1.
REQ-035 Lead pass: P_TURN lead=1, p_req=1, p_pass=1 -> err pulse, p_grant stays 1, counts unchanged.
REQ-036 Play and pass:
- player plays 2 -> p_left=2, c_grant=1, lead=0
- computer passes -> p_grant=1, lead=1.
REQ-037 Illegal count: p_left=2, p_num=3 -> err, no change; p_num=2 -> game_over=1, winner=0.
REQ-038 deal_done held low -> err after 255 cycles, card_gen retried twice; third timeout -> deal_fail=1, IDLE.
REQ-039 restart asserted in C_TURN alongside c_req -> next cycle IDLE, all outputs at reset values, move not applied.

Source files
------------

// File: rtl/big2_pkg.sv
// Shared definitions for the Big Two turn controller: state encoding and game constants.
package big2_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEAL_REQ  = 3'd1,
        S_DEAL_WAIT = 3'd2,
        S_P_TURN    = 3'd3,
        S_C_TURN    = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    localparam logic [2:0] HAND_SIZE    = 3'd4;
    localparam logic [7:0] DEAL_TIMEOUT = 8'd255;
    localparam logic [1:0] MAX_RETRY    = 2'd3;
    // The player is always dealt this card, so the player always opens.
    localparam logic [5:0] LOW_CARD     = 6'b000011;

endpackage

// File: rtl/big2_deal_watchdog.sv
// Watches the dealer handshake: deal_done rising-edge detect, wait timeout and retry budget.
module big2_deal_watchdog
    import big2_pkg::*;
(
    input  logic clk,
    input  logic restart,
    input  logic deal_done,
    input  logic active,
    input  logic clear,
    input  logic clear_retry,
    output logic done_edge,
    output logic timeout,
    output logic fail
);

    logic       done_prev;
    logic [7:0] wait_cnt;
    logic [1:0] retry_cnt;

    assign done_edge = deal_done & ~done_prev;
    // Timeout fires in the cycle the count sits at its limit; a simultaneous edge wins.
    assign timeout   = active & (wait_cnt == DEAL_TIMEOUT) & ~done_edge;
    assign fail      = timeout & (retry_cnt == (MAX_RETRY - 2'd1));

    always_ff @(posedge clk) begin
        if (restart) begin
            done_prev <= 1'b0;
            wait_cnt  <= 8'd0;
            retry_cnt <= 2'd0;
        end else begin
            done_prev <= deal_done;
            if (clear) begin
                wait_cnt <= 8'd0;
            end else if (active && (wait_cnt != DEAL_TIMEOUT)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (clear_retry) begin
                retry_cnt <= 2'd0;
            end else if (timeout) begin
                retry_cnt <= retry_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/big2_turn_ctrl.sv
// Two-player Big Two game sequencer: deal handshake, turn ownership, lead tracking and win detect.
module big2_turn_ctrl
    import big2_pkg::*;
(
    input  logic       clka,
    input  logic       restart,
    input  logic       start,
    input  logic [3:0] seed_in,
    input  logic       deal_done,
    input  logic       p_req,
    input  logic       c_req,
    input  logic       p_pass,
    input  logic       c_pass,
    input  logic [2:0] p_num,
    input  logic [2:0] c_num,
    output logic       card_gen,
    output logic [3:0] seed,
    output logic       p_grant,
    output logic       c_grant,
    output logic       lead,
    output logic [2:0] p_left,
    output logic [2:0] c_left,
    output logic       game_over,
    output logic       winner,
    output logic       err,
    output logic       deal_fail,
    output state_t     state
);

    state_t     cur_state, nxt_state;
    logic [3:0] seed_r, nxt_seed;
    logic       lead_r, nxt_lead;
    logic [2:0] p_left_r, nxt_p_left, c_left_r, nxt_c_left;
    logic       winner_r, nxt_winner;
    logic       err_r, nxt_err;
    logic       fail_r, nxt_fail;
    logic       wd_clear, wd_clear_retry;
    logic       done_edge, timeout, wd_fail;
    logic       is_p, mv_req, mv_pass;
    logic [2:0] mv_num, mv_left, new_left;
    state_t     opp_state;

    big2_deal_watchdog u_watchdog (
        .clk         (clka),
        .restart     (restart),
        .deal_done   (deal_done),
        .active      (cur_state == S_DEAL_WAIT),
        .clear       (wd_clear),
        .clear_retry (wd_clear_retry),
        .done_edge   (done_edge),
        .timeout     (timeout),
        .fail        (wd_fail)
    );

    always_ff @(posedge clka) begin
        if (restart) begin
            cur_state <= S_IDLE;
            seed_r    <= 4'd0;
            lead_r    <= 1'b0;
            p_left_r  <= 3'd0;
            c_left_r  <= 3'd0;
            winner_r  <= 1'b0;
            err_r     <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            seed_r    <= nxt_seed;
            lead_r    <= nxt_lead;
            p_left_r  <= nxt_p_left;
            c_left_r  <= nxt_c_left;
            winner_r  <= nxt_winner;
            err_r     <= nxt_err;
            fail_r    <= nxt_fail;
        end
    end

    always_comb begin
        nxt_state      = cur_state;
        nxt_seed       = seed_r;
        nxt_lead       = lead_r;
        nxt_p_left     = p_left_r;
        nxt_c_left     = c_left_r;
        nxt_winner     = winner_r;
        nxt_err        = 1'b0;
        nxt_fail       = fail_r;
        wd_clear       = 1'b0;
        wd_clear_retry = 1'b0;
        // Only the turn owner's inputs are looked at; the other side is ignored.
        is_p      = (cur_state == S_P_TURN);
        mv_req    = is_p ? p_req  : c_req;
        mv_pass   = is_p ? p_pass : c_pass;
        mv_num    = is_p ? p_num  : c_num;
        mv_left   = is_p ? p_left_r : c_left_r;
        opp_state = is_p ? S_C_TURN : S_P_TURN;
        new_left  = mv_left - mv_num;

        case (cur_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    nxt_seed       = seed_in;
                    nxt_fail       = 1'b0;
                    wd_clear_retry = 1'b1;
                    nxt_state      = S_DEAL_REQ;
                end
            end
            S_DEAL_REQ: begin
                wd_clear  = 1'b1;
                nxt_state = S_DEAL_WAIT;
            end
            S_DEAL_WAIT: begin
                if (done_edge) begin
                    nxt_p_left = HAND_SIZE;
                    nxt_c_left = HAND_SIZE;
                    nxt_lead   = 1'b1;
                    nxt_state  = S_P_TURN;
                end else if (timeout) begin
                    nxt_err = 1'b1;
                    if (wd_fail) begin
                        nxt_fail  = 1'b1;
                        nxt_state = S_IDLE;
                    end else begin
                        nxt_state = S_DEAL_REQ;
                    end
                end
            end
            S_P_TURN, S_C_TURN: begin
                if (mv_req) begin
                    if (mv_pass) begin
                        if (lead_r) begin
                            nxt_err = 1'b1;
                        end else begin
                            nxt_lead  = 1'b1;
                            nxt_state = opp_state;
                        end
                    end else if ((mv_num == 3'd0) || (mv_num > mv_left)) begin
                        nxt_err = 1'b1;
                    end else begin
                        if (is_p) nxt_p_left = new_left;
                        else      nxt_c_left = new_left;
                        nxt_lead = 1'b0;
                        if (new_left == 3'd0) begin
                            nxt_winner = ~is_p;
                            nxt_state  = S_OVER;
                        end else begin
                            nxt_state = opp_state;
                        end
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign card_gen  = (cur_state == S_DEAL_REQ);
    assign p_grant   = (cur_state == S_P_TURN);
    assign c_grant   = (cur_state == S_C_TURN);
    assign game_over = (cur_state == S_OVER);
    assign seed      = seed_r;
    assign lead      = lead_r;
    assign p_left    = p_left_r;
    assign c_left    = c_left_r;
    assign winner    = winner_r;
    assign err       = err_r;
    assign deal_fail = fail_r;
    assign state     = cur_state;

endmodule
